// File: rtl/serial_adder_pkg.sv
// Shared constants and state encoding for the bit-serial adder.
package serial_adder_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder; the only arithmetic in the serial adder.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell, one carry flop, LSB first.
// Takes WIDTH SHIFT cycles plus one DONE cycle per addition.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_r, b_r;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s, fa_c;
  logic             last;
  logic             accept;

  // Start is honoured outside SHIFT only; mid-add starts are dropped.
  assign accept = start && (state != SHIFT);
  assign last   = (cnt == CW'(WIDTH - 1));
  assign busy   = (state == SHIFT);
  assign done   = (state == DONE);

  fa_cell u_fa (
    .a     (a_r[0]),
    .b     (b_r[0]),
    .c     (carry),
    .sum   (fa_s),
    .carry (fa_c)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: DONE lasts one cycle and may chain straight into SHIFT.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: load on accept, then shift one bit per SHIFT cycle.
  // Sum bits enter from the MSB so bit 0 lands at the LSB after WIDTH shifts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r     <= '0;
      b_r     <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      sum_out <= '0;
      cout    <= 1'b0;
    end else if (accept) begin
      a_r     <= a_in;
      b_r     <= b_in;
      carry   <= cin;
      cnt     <= '0;
      sum_out <= '0;
    end else if (state == SHIFT) begin
      sum_out <= {fa_s, sum_out[WIDTH-1:1]};
      a_r     <= a_r >> 1;
      b_r     <= b_r >> 1;
      carry   <= fa_c;
      cnt     <= cnt + CW'(1);
      // Carry-out is only published with the final bit.
      if (last) cout <= fa_c;
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed and table-driven checks for serial_adder at WIDTH=8.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a_in, b_in;
  logic       cin;
  logic       busy, done;
  logic [7:0] sum_out;
  logic       cout;

  int total = 0;
  int passed = 0;
  int overlap = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [7:0] s;
    logic       co;
  } vec_t;

  vec_t vecs[11];

  serial_adder #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a_in    (a_in),
    .b_in    (b_in),
    .cin     (cin),
    .busy    (busy),
    .done    (done),
    .sum_out (sum_out),
    .cout    (cout)
  );

  always #5 clk = ~clk;

  // busy and done must never overlap
  always @(negedge clk) if (busy && done) overlap++;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Launch one add and wait (bounded) for done; returns busy-cycle count.
  task automatic do_add(input logic [7:0] a, input logic [7:0] b, input logic c,
                        output int nbusy, output bit tmo);
    @(negedge clk);
    a_in = a; b_in = b; cin = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nbusy = 0;
    while (!done && nbusy < 50) begin
      if (busy) nbusy++;
      @(negedge clk);
    end
    tmo = !done;
  endtask

  initial begin
    int nb;
    bit tmo;
    int cyc, ndone, idle, last_done, gap_bad;
    logic [8:0] ref9;
    logic [7:0] ra, rb;
    logic rc;

    vecs[0]  = '{8'h05, 8'h03, 1'b0, 8'h08, 1'b0};
    vecs[1]  = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2]  = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3]  = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[4]  = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs[5]  = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[6]  = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
    vecs[7]  = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
    vecs[8]  = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
    vecs[9]  = '{8'h3C, 8'hC3, 1'b1, 8'h00, 1'b1};
    vecs[10] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};

    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_sum", sum_out, 0);
    check("reset_cout", cout, 0);
    rst = 1'b0;

    // Table-driven adds
    foreach (vecs[i]) begin
      do_add(vecs[i].a, vecs[i].b, vecs[i].c, nb, tmo);
      check($sformatf("v%0d_timeout", i), tmo, 0);
      check($sformatf("v%0d_busy_cycles", i), nb, 8);
      check($sformatf("v%0d_sum", i), sum_out, vecs[i].s);
      check($sformatf("v%0d_cout", i), cout, vecs[i].co);
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", i), done, 0);
      check($sformatf("v%0d_hold_sum", i), sum_out, vecs[i].s);
    end

    // Start during SHIFT cycle 3 is ignored
    @(negedge clk);
    a_in = 8'h10; b_in = 8'h20; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; nb = 0;
    while (!done && nb < 50) begin
      if (busy) nb++;
      if (nb == 3) begin a_in = 8'hAA; b_in = 8'h55; cin = 1'b1; start = 1'b1; end
      else start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    check("ign_timeout", !done, 0);
    check("ign_busy_cycles", nb, 8);
    check("ign_sum", sum_out, 8'h30);
    check("ign_cout", cout, 0);

    // start held high: done every 9 cycles, never idle
    @(negedge clk);
    a_in = 8'h01; b_in = 8'h01; cin = 1'b0; start = 1'b1;
    ndone = 0; idle = 0; last_done = 0; gap_bad = 0;
    for (cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (!busy && !done) idle++;
      if (done) begin
        ndone++;
        check($sformatf("b2b_sum%0d", ndone), sum_out, 8'h02);
        if (cyc - last_done != 9) gap_bad++;
        last_done = cyc;
      end
    end
    start = 1'b0;
    check("b2b_ndone", ndone, 4);
    check("b2b_gap", gap_bad, 0);
    check("b2b_idle", idle, 0);
    repeat (12) @(negedge clk);

    // Reset in SHIFT cycle 4 aborts without done
    a_in = 8'h0F; b_in = 8'h0F; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; nb = 0;
    while (nb < 4 && !done) begin
      if (busy) nb++;
      if (nb < 4) @(negedge clk);
    end
    check("abort_reached", nb, 4);
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_sum", sum_out, 0);
    check("abort_cout", cout, 0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (12) begin @(negedge clk); if (done) ndone++; end
    check("abort_no_done", ndone, 0);
    do_add(8'h07, 8'h09, 1'b0, nb, tmo);
    check("post_rst_timeout", tmo, 0);
    check("post_rst_sum", sum_out, 8'h10);
    check("post_rst_cout", cout, 0);

    // Random operand pairs against a+b+cin
    for (int k = 0; k < 1000; k++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      ref9 = {1'b0, ra} + {1'b0, rb} + {8'b0, rc};
      do_add(ra, rb, rc, nb, tmo);
      check($sformatf("rnd%0d", k), {tmo, cout, sum_out}, {1'b0, ref9});
    end

    check("busy_done_overlap", overlap, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk and rst.
REQ-002 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range is 2..32.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 start  input  1  request to begin an addition; sampled on the rising edge of clk.
REQ-006 a_in  input  WIDTH  operand A; sampled only on an accepted start.
REQ-007 b_in  input  WIDTH  operand B; sampled only on an accepted start.
REQ-008 cin  input  1  carry-in; sampled only on an accepted start.
REQ-009 busy  output  1  high while an addition is in progress (SHIFT state).
REQ-010 done  output  1  single-cycle pulse: the result is valid.
REQ-011 sum_out  output  WIDTH  result sum; holds the last result.
REQ-012 cout  output  1  result carry-out; holds the last result.

Function
REQ-013 The block SHALL add a_in, b_in and cin bit-serially, LSB first, using one full-adder cell and one carry flip-flop.
REQ-014 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-015 Start SHALL be accepted only in IDLE or DONE; an accepted start loads the operands, loads carry with cin, clears the bit counter, clears sum_out, and moves to SHIFT.
REQ-016 In SHIFT, each cycle SHALL:
- add a[0], b[0] and carry;
- shift the sum bit into the result register from the MSB side;
- shift both operand registers right by one;
- update carry;
- increment the counter.
REQ-017 The block SHALL move from SHIFT to DONE on the cycle that processes bit WIDTH-1 (counter == WIDTH-1).
REQ-018 DONE SHALL last exactly one cycle with done=1, then return to IDLE unless start is high in that cycle; in that case, REQ-015 applies.
REQ-019 Latency: with start accepted at edge k, done SHALL be high in the cycle following edge k+WIDTH.
REQ-020 start SHALL be ignored while busy=1; operands, counter and result SHALL be unaffected.
REQ-021 sum_out and cout SHALL be updated to the final values at entry to DONE and held until the next accepted start.
REQ-022 The result SHALL be exact modulo 2^WIDTH, with cout = bit WIDTH of a_in+b_in+cin.
REQ-023 busy and done SHALL never be high in the same cycle.

Reset
REQ-024 rst=1 SHALL immediately force:
- state to IDLE;
- busy=0, done=0;
- sum_out=0, cout=0;
- carry, counter and operand registers to 0.
REQ-025 Reset asserted during SHIFT SHALL abort the addition without producing a done pulse.
REQ-026 After rst deasserts, the first start sampled on a rising edge SHALL be accepted.

Structure
REQ-027 The state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and the default WIDTH constant SHALL live in a shared package, serial_adder_pkg.
REQ-028 The one-bit add SHALL be a separate combinational sub-module, fa_cell (ports a, b, c, sum, carry), instantiated once.
REQ-029 The counter SHALL be $clog2(WIDTH) bits wide.

Verification
REQ-030 WIDTH=8: a_in=8'h05, b_in=8'h03, cin=0, start pulse -> busy for 8 cycles, then done pulse; sum_out=8'h08, cout=0.
REQ-031 a_in=8'hFF, b_in=8'h01, cin=0 -> sum_out=8'h00, cout=1; a_in=8'hFF, b_in=8'hFF, cin=1 -> sum_out=8'hFF, cout=1.
REQ-032 Start with 8'h10+8'h20, then a second start with 8'hAA+8'h55 at SHIFT cycle 3 -> the second start is ignored; result is 8'h30, cout=0.
REQ-033 start held high continuously with a fixed 8'h01+8'h01 -> back-to-back results 8'h02, with done every 9 cycles and no IDLE cycle between them.
REQ-034 rst asserted at SHIFT cycle 4 -> busy, done, sum_out and cout are 0 at once, with no done pulse; a new 8'h07+8'h09 after reset -> 8'h10.
REQ-035 A random self-check of 1000 operand pairs against a_in+b_in+cin -> zero mismatches.
